// File: rtl/vga_pkg.sv
// Shared constants and colour helpers for the VGA demo pixel path.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  typedef logic [5:0] colour_t;

  localparam colour_t WAVE_COL = 6'b001100;
  localparam colour_t BG_COL   = 6'b000001;

  function automatic colour_t palette(input logic [1:0] sel);
    unique case (sel)
      2'd0:    return 6'b111111;
      2'd1:    return 6'b110000;
      2'd2:    return 6'b111100;
      default: return 6'b000011;
    endcase
  endfunction

endpackage

// File: rtl/vga_overlay_mixer_if.sv
// Pixel-stream bundle into the overlay mixer: timing/position in, colour/sync out.
interface vga_overlay_mixer_if;
  logic       hsync_in;
  logic       vsync_in;
  logic       display_on_in;
  logic [9:0] x;
  logic [9:0] y;
  logic       overlay_active;
  logic       pause;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;
  logic       hsync;
  logic       vsync;

  modport master (
    output hsync_in, vsync_in, display_on_in, x, y, overlay_active, pause,
    input  r, g, b, hsync, vsync
  );

  modport slave (
    input  hsync_in, vsync_in, display_on_in, x, y, overlay_active, pause,
    output r, g, b, hsync, vsync
  );
endinterface

// File: rtl/sine_lut.sv
// 64-point signed sine, amplitude 63, built from a quarter-wave table by symmetry.
module sine_lut (
  input  logic        [5:0] i_idx,
  output logic signed [6:0] o_sine
);

  logic [4:0] w_qidx;
  logic [5:0] w_mag;

  // Second and fourth quadrants mirror the table: 16 - low bits.
  assign w_qidx = i_idx[4] ? (5'd16 - {1'b0, i_idx[3:0]}) : {1'b0, i_idx[3:0]};

  always_comb begin
    w_mag = 6'd0;
    case (w_qidx)
      5'd0:    w_mag = 6'd0;
      5'd1:    w_mag = 6'd6;
      5'd2:    w_mag = 6'd12;
      5'd3:    w_mag = 6'd18;
      5'd4:    w_mag = 6'd24;
      5'd5:    w_mag = 6'd30;
      5'd6:    w_mag = 6'd35;
      5'd7:    w_mag = 6'd40;
      5'd8:    w_mag = 6'd45;
      5'd9:    w_mag = 6'd49;
      5'd10:   w_mag = 6'd52;
      5'd11:   w_mag = 6'd56;
      5'd12:   w_mag = 6'd58;
      5'd13:   w_mag = 6'd60;
      5'd14:   w_mag = 6'd62;
      5'd15:   w_mag = 6'd63;
      5'd16:   w_mag = 6'd63;
      default: w_mag = 6'd0;
    endcase
  end

  assign o_sine = i_idx[5] ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});

endmodule

// File: rtl/vga_overlay_mixer.sv
// Final pixel stage: text overlay over an animated sine band and background, 2-cycle latency.
module vga_overlay_mixer
  import vga_pkg::*;
#(
  parameter int unsigned PHASE_STEP  = 1,
  parameter int unsigned BAND        = 4,
  parameter int unsigned WAVE_CENTRE = 240
) (
  input logic                clk,
  input logic                rst,
  vga_overlay_mixer_if.slave vid
);

  logic [5:0] r_phase;
  logic [4:0] r_frame_cnt;
  logic       r_tick_pos;
  logic       w_tick_pos;
  logic       w_tick;

  // Frame tick is edge-detected so a held (0,480) position advances only once.
  assign w_tick_pos = (vid.x == 10'd0) && (vid.y == 10'(V_ACTIVE));
  assign w_tick     = w_tick_pos && !r_tick_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase     <= 6'd0;
      r_frame_cnt <= 5'd0;
      r_tick_pos  <= 1'b0;
    end else begin
      r_tick_pos <= w_tick_pos;
      if (w_tick && !vid.pause) begin
        r_phase     <= r_phase + 6'(PHASE_STEP);
        r_frame_cnt <= r_frame_cnt + 5'd1;
      end
    end
  end

  logic [5:0]        w_idx;
  logic signed [6:0] w_sine;
  logic              w_unused_x;

  assign w_idx      = vid.x[8:3] + r_phase;
  assign w_unused_x = ^{vid.x[9], vid.x[2:0]};

  sine_lut u_sine_lut (
    .i_idx  (w_idx),
    .o_sine (w_sine)
  );

  logic              r_s1_hs;
  logic              r_s1_vs;
  logic              r_s1_de;
  logic              r_s1_ov;
  logic [9:0]        r_s1_y;
  logic signed [6:0] r_s1_sine;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_hs   <= 1'b1;
      r_s1_vs   <= 1'b1;
      r_s1_de   <= 1'b0;
      r_s1_ov   <= 1'b0;
      r_s1_y    <= 10'd0;
      r_s1_sine <= 7'sd0;
    end else begin
      r_s1_hs   <= vid.hsync_in;
      r_s1_vs   <= vid.vsync_in;
      r_s1_de   <= vid.display_on_in;
      r_s1_ov   <= vid.overlay_active;
      r_s1_y    <= vid.y;
      r_s1_sine <= w_sine;
    end
  end

  logic signed [10:0] w_wave_y;
  logic signed [10:0] w_diff;
  logic signed [10:0] w_abs;
  logic               w_on_band;
  colour_t            w_colour;

  assign w_wave_y  = $signed(11'(WAVE_CENTRE)) + {{4{r_s1_sine[6]}}, r_s1_sine};
  assign w_diff    = $signed({1'b0, r_s1_y}) - w_wave_y;
  assign w_abs     = w_diff[10] ? -w_diff : w_diff;
  assign w_on_band = w_abs < $signed(11'(BAND));

  always_comb begin
    w_colour = BG_COL;
    if (!r_s1_de) begin
      w_colour = 6'b000000;
    end else if (r_s1_ov) begin
      w_colour = palette(r_frame_cnt[4:3]);
    end else if (w_on_band) begin
      w_colour = WAVE_COL;
    end
  end

  colour_t r_rgb;
  logic    r_hs;
  logic    r_vs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb <= 6'b000000;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else begin
      r_rgb <= w_colour;
      r_hs  <= r_s1_hs;
      r_vs  <= r_s1_vs;
    end
  end

  assign vid.r     = r_rgb[5:4];
  assign vid.g     = r_rgb[3:2];
  assign vid.b     = r_rgb[1:0];
  assign vid.hsync = r_hs;
  assign vid.vsync = r_vs;

endmodule

// File: tb/tb_vga_overlay_mixer.sv
// Scoreboard bench for vga_overlay_mixer: directed pixels, frame ticks, palette and phase wrap.
module tb_vga_overlay_mixer;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_overlay_mixer_if vid ();

  vga_overlay_mixer #(
    .PHASE_STEP  (1),
    .BAND        (4),
    .WAVE_CENTRE (240)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vid (vid)
  );

  typedef struct {
    int unsigned cyc;
    logic [5:0]  rgb;
    logic        hs;
    logic        vs;
    string       name;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  localparam logic [5:0] WAVE = 6'b001100;
  localparam logic [5:0] BG   = 6'b000001;
  localparam logic [5:0] BLK  = 6'b000000;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: output is presented every cycle; compare everything tagged for this cycle.
  exp_t m_e;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      n_tests++;
      if (m_e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked, now cycle %0d",
                 m_e.name, m_e.cyc, cyc);
      end else if ({vid.r, vid.g, vid.b, vid.hsync, vid.vsync} !== {m_e.rgb, m_e.hs, m_e.vs}) begin
        n_fail++;
        $display("FAIL %s: got rgb=%b hs=%b vs=%b, expected rgb=%b hs=%b vs=%b", m_e.name,
                 {vid.r, vid.g, vid.b}, vid.hsync, vid.vsync, m_e.rgb, m_e.hs, m_e.vs);
      end
    end
  end

  task automatic push(input int unsigned c, input logic [5:0] rgb, input logic hs,
                      input logic vs, input string name);
    exp_t e;
    e.cyc  = c;
    e.rgb  = rgb;
    e.hs   = hs;
    e.vs   = vs;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic drive(input string name, input logic rs, input logic de, input logic ov,
                       input logic pz, input logic hs, input logic vs,
                       input logic [9:0] px, input logic [9:0] py, input logic [5:0] rgb);
    rst                = rs;
    vid.display_on_in  = de;
    vid.overlay_active = ov;
    vid.pause          = pz;
    vid.hsync_in       = hs;
    vid.vsync_in       = vs;
    vid.x              = px;
    vid.y              = py;
    if (rs) begin
      // Reset flushes whatever was still in flight.
      while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
      push(cyc + 1, BLK, 1'b1, 1'b1, {name, "_n1"});
      push(cyc + 2, BLK, 1'b1, 1'b1, {name, "_n2"});
    end else begin
      push(cyc + 2, rgb, hs, vs, name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input string name, input logic [9:0] px, input logic [9:0] py,
                     input logic ov, input logic [5:0] rgb);
    drive(name, 1'b0, 1'b1, ov, 1'b0, 1'b1, 1'b1, px, py, rgb);
  endtask

  task automatic tick(input logic pz);
    drive("tick", 1'b0, 1'b0, 1'b0, pz, 1'b1, 1'b1, 10'd0, 10'd480, BLK);
  endtask

  task automatic idle();
    drive("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd1, 10'd480, BLK);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0);
      idle();
    end
  endtask

  task automatic rand_reset(input string name);
    drive(name, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), BLK);
  endtask

  initial begin
    rst                = 1'b1;
    vid.display_on_in  = 1'b0;
    vid.overlay_active = 1'b0;
    vid.pause          = 1'b0;
    vid.hsync_in       = 1'b1;
    vid.vsync_in       = 1'b1;
    vid.x              = 10'd0;
    vid.y              = 10'd0;

    rand_reset("rst0");
    rand_reset("rst1");

    // First tick after reset: phase 1 -> x=0 gives idx 1, sine 6, wave_y 246.
    tick(1'b0);
    idle();
    pix("ph1_y246", 10'd0, 10'd246, 1'b0, WAVE);
    pix("ph1_y242", 10'd0, 10'd242, 1'b0, BG);

    // Latency / sync pass-through; x=100 idx 13 -> wave_y 300, y=100 is background.
    pix("lat_pre", 10'd100, 10'd100, 1'b0, BG);
    pix("lat_ov", 10'd100, 10'd100, 1'b1, 6'b111111);
    drive("hs_pulse", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd100, 10'd100, BG);
    drive("vs_pulse", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd100, 10'd100, BG);
    pix("lat_post", 10'd100, 10'd100, 1'b0, BG);

    // Mid-stream reset returns phase and frame count to 0.
    rand_reset("rst_mid");

    pix("band_y240", 10'd0, 10'd240, 1'b0, WAVE);
    pix("band_y243", 10'd0, 10'd243, 1'b0, WAVE);
    pix("band_y244", 10'd0, 10'd244, 1'b0, BG);
    pix("band_y237", 10'd0, 10'd237, 1'b0, WAVE);
    pix("band_y236", 10'd0, 10'd236, 1'b0, BG);
    pix("peak_y303", 10'd128, 10'd303, 1'b0, WAVE);
    pix("peak_y306", 10'd128, 10'd306, 1'b0, WAVE);
    pix("peak_y307", 10'd128, 10'd307, 1'b0, BG);
    pix("trough_y177", 10'd384, 10'd177, 1'b0, WAVE);
    pix("trough_y173", 10'd384, 10'd173, 1'b0, BG);
    pix("zero_x256", 10'd256, 10'd240, 1'b0, WAVE);

    // Held tick position advances once: phase 1 (wave_y 246) makes both 243 and 249 on-band.
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    idle();
    pix("hold_y243", 10'd0, 10'd243, 1'b0, WAVE);
    pix("hold_y249", 10'd0, 10'd249, 1'b0, WAVE);

    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    idle();
    pix("pause_y243", 10'd0, 10'd243, 1'b0, WAVE);
    pix("pause_y249", 10'd0, 10'd249, 1'b0, WAVE);

    // frame_cnt is 1 here; palette index changes at 8, 16, 24, wraps at 32.
    ticks(6);
    pix("pal_f7", 10'd100, 10'd100, 1'b1, 6'b111111);
    ticks(1);
    pix("pal_f8", 10'd100, 10'd100, 1'b1, 6'b110000);
    ticks(8);
    pix("pal_f16", 10'd100, 10'd100, 1'b1, 6'b111100);
    ticks(8);
    pix("pal_f24", 10'd100, 10'd100, 1'b1, 6'b000011);
    ticks(8);
    pix("pal_f32", 10'd100, 10'd100, 1'b1, 6'b111111);

    // Phase is 32 now; 32 more ticks wrap it to 0 (wave_y 240).
    ticks(32);
    pix("wrap_y243", 10'd0, 10'd243, 1'b0, WAVE);
    pix("wrap_y237", 10'd0, 10'd237, 1'b0, WAVE);
    pix("wrap_y244", 10'd0, 10'd244, 1'b0, BG);
    pix("wrap_pal", 10'd100, 10'd100, 1'b1, 6'b111111);

    // Blanking beats overlay and band; syncs still pass through.
    drive("blank_sync0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd240, BLK);
    drive("blank_hs1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 10'd240, BLK);
    pix("after_blank", 10'd0, 10'd240, 1'b0, WAVE);

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
